uart_stream_gen: RTL and testbench

//  Parametrised byte-stream generator driving a uart_send-style transmitter (DATA/DATA_READY/IDLE).

---
 rtl/uart_stream_gen.sv | 169 ++++++++++++++++
 tb/tb_uart_stream_gen.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_stream_gen.sv
// uart_stream_gen
//   Byte-stream generator feeding a uart_send-style transmitter. It emits
//   ASCII ramps (saturating or wrapping), a constant byte, or LFSR bytes.
//   Output comes in finite bursts or as a continuous stream. An optional
//   idle gap follows each byte, and a watchdog covers the transmitter
//   handshake.
//
// Ports
//   CLK         in   1       clock
//   RST         in   1       synchronous, active-high reset
//   EN          in   1       start/continue request (level)
//   MODE        in   2       0 ramp-hold, 1 ramp-wrap, 2 const, 3 LFSR
//   BURST_LEN   in   CNT_W   bytes per burst, 0 = continuous while EN=1
//   TX_IDLE     in   1       transmitter idle
//   TX_DATA     out  DATA_W  byte presented to the transmitter
//   TX_VALID    out  1       one-cycle send strobe
//   BUSY        out  1       high whenever a burst is in progress
//   DONE        out  1       one-cycle pulse when a finite burst completes
//   ERR         out  1       sticky handshake timeout flag
//   SENT_COUNT  out  CNT_W   bytes strobed in the current/last burst (saturating)

module uart_stream_gen #(
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] START_CHAR  = 8'h30,
  parameter logic [DATA_W-1:0] END_CHAR    = 8'h39,
  parameter int                GAP_CYCLES  = 0,
  parameter int                CNT_W       = 16,
  parameter int                ACK_TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [1:0]        MODE,
  input  logic [CNT_W-1:0]  BURST_LEN,
  input  logic              TX_IDLE,
  output logic [DATA_W-1:0] TX_DATA,
  output logic              TX_VALID,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [CNT_W-1:0]  SENT_COUNT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_LO,
    S_WAIT_HI,
    S_GAP
  } state_t;

  // A zero seed would lock the LFSR at zero, so substitute 1.
  localparam logic [DATA_W-1:0] LFSR_SEED = (START_CHAR == '0) ? DATA_W'(1) : START_CHAR;

  localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t             state;
  logic [1:0]         mode_q;
  logic [CNT_W-1:0]   burst_len_q;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [GAP_W-1:0]   gap_cnt;

  logic [DATA_W-1:0]  next_byte;
  logic [DATA_W-1:0]  lfsr_next;
  logic               at_boundary;
  logic               burst_done;

  // Taps on bits 5,4,3 with shift-left into bit 0. If the shifted value
  // ever becomes zero, it is reloaded from the seed, so zero is never emitted.
  always_comb begin
    lfsr_next = {TX_DATA[DATA_W-2:0], TX_DATA[5] ^ TX_DATA[4] ^ TX_DATA[3]};
    next_byte = START_CHAR;
    case (mode_q)
      2'd0:    next_byte = (TX_DATA >= END_CHAR) ? TX_DATA : TX_DATA + 1'b1;
      2'd1:    next_byte = (TX_DATA >= END_CHAR) ? START_CHAR : TX_DATA + 1'b1;
      2'd2:    next_byte = START_CHAR;
      default: next_byte = (lfsr_next == '0) ? LFSR_SEED : lfsr_next;
    endcase
  end

  // The byte boundary is the moment the transmitter has gone idle again and
  // any gap has elapsed. With no gap configured, this occurs directly in S_WAIT_HI.
  always_comb begin
    at_boundary = ((state == S_WAIT_HI) && TX_IDLE && (GAP_CYCLES == 0)) ||
                  ((state == S_GAP) && (gap_cnt == GAP_LAST));
    burst_done  = (burst_len_q != '0) && (SENT_COUNT == burst_len_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      TX_DATA     <= START_CHAR;
      TX_VALID    <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      ERR         <= 1'b0;
      SENT_COUNT  <= '0;
      mode_q      <= 2'd0;
      burst_len_q <= '0;
      tmo_cnt     <= '0;
      gap_cnt     <= '0;
    end else begin
      TX_VALID <= 1'b0;
      DONE     <= 1'b0;
      if (at_boundary) begin
        if (burst_done) begin
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end else if (!EN) begin
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end else begin
          TX_DATA <= next_byte;
          state   <= S_ISSUE;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (EN) begin
              mode_q      <= MODE;
              burst_len_q <= BURST_LEN;
              TX_DATA     <= (MODE == 2'd3) ? LFSR_SEED : START_CHAR;
              SENT_COUNT  <= '0;
              ERR         <= 1'b0;
              BUSY        <= 1'b1;
              state       <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (TX_IDLE) begin
              TX_VALID <= 1'b1;
              if (SENT_COUNT != '1) SENT_COUNT <= SENT_COUNT + 1'b1;
              tmo_cnt  <= '0;
              state    <= S_WAIT_LO;
            end
          end
          S_WAIT_LO: begin
            if (!TX_IDLE) begin
              state <= S_WAIT_HI;
            end else if (tmo_cnt == TMO_LAST) begin
              ERR   <= 1'b1;
              BUSY  <= 1'b0;
              state <= S_IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          // Only reached with a nonzero gap; the zero-gap case leaves via at_boundary.
          S_WAIT_HI: begin
            if (TX_IDLE) begin
              gap_cnt <= '0;
              state   <= S_GAP;
            end
          end
          S_GAP: gap_cnt <= gap_cnt + 1'b1;
          default: begin
            BUSY  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_stream_gen.sv
// tb_uart_stream_gen
//   Drives uart_stream_gen against a simple uart_send model. The model drops
//   IDLE for 10 cycles after a strobe. Each byte the DUT strobes is checked
//   against a queue of expected bytes. A second instance with a 5-cycle gap
//   covers the continuous/abort case.

module tb_uart_stream_gen;

  localparam int CNT_W = 16;
  localparam logic [7:0] START = 8'h30;
  localparam logic [7:0] ENDC  = 8'h39;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             EN = 1'b0;
  logic             EN_G = 1'b0;
  logic [1:0]       MODE = 2'd0;
  logic [CNT_W-1:0] BURST_LEN = '0;
  logic             tx_idle = 1'b1;
  logic             tx_idle_g = 1'b1;
  logic             stuck = 1'b0;

  logic [7:0]       tx_data, tx_data_g;
  logic             tx_valid, tx_valid_g;
  logic             busy, busy_g, done, done_g, err, err_g;
  logic [CNT_W-1:0] sent_count, sent_count_g;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_g[$];
  int strobes = 0, extra = 0, dones = 0, zeros = 0;
  int strobes_g = 0, extra_g = 0, dones_g = 0, idle_run = 0;
  int idle_cnt = 0, idle_cnt_g = 0;

  always #5 CLK = ~CLK;

  uart_stream_gen #(.GAP_CYCLES(0)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .BURST_LEN(BURST_LEN),
    .TX_IDLE(tx_idle), .TX_DATA(tx_data), .TX_VALID(tx_valid), .BUSY(busy),
    .DONE(done), .ERR(err), .SENT_COUNT(sent_count)
  );

  uart_stream_gen #(.GAP_CYCLES(5)) dut_g (
    .CLK(CLK), .RST(RST), .EN(EN_G), .MODE(MODE), .BURST_LEN(BURST_LEN),
    .TX_IDLE(tx_idle_g), .TX_DATA(tx_data_g), .TX_VALID(tx_valid_g), .BUSY(busy_g),
    .DONE(done_g), .ERR(err_g), .SENT_COUNT(sent_count_g)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] modelNext(input logic [1:0] m, input logic [7:0] cur);
    logic [7:0] l;
    case (m)
      2'd0:    return (cur >= ENDC) ? cur : cur + 8'd1;
      2'd1:    return (cur >= ENDC) ? START : cur + 8'd1;
      2'd2:    return START;
      default: begin
        l = {cur[6:0], cur[5] ^ cur[4] ^ cur[3]};
        return (l == 8'h00) ? START : l;
      end
    endcase
  endfunction

  // uart_send models: IDLE falls the cycle after a strobe and stays low for 10 cycles.
  always @(posedge CLK) begin
    if (RST) begin
      tx_idle  <= 1'b1;
      idle_cnt <= 0;
    end else if (tx_valid && !stuck) begin
      tx_idle  <= 1'b0;
      idle_cnt <= 10;
    end else if (idle_cnt > 0) begin
      idle_cnt <= idle_cnt - 1;
      if (idle_cnt == 1) tx_idle <= 1'b1;
    end
  end

  always @(posedge CLK) begin
    if (RST) begin
      tx_idle_g  <= 1'b1;
      idle_cnt_g <= 0;
    end else if (tx_valid_g) begin
      tx_idle_g  <= 1'b0;
      idle_cnt_g <= 10;
    end else if (idle_cnt_g > 0) begin
      idle_cnt_g <= idle_cnt_g - 1;
      if (idle_cnt_g == 1) tx_idle_g <= 1'b1;
    end
  end

  always @(negedge CLK) begin
    if (tx_valid) begin
      strobes++;
      if (tx_data == 8'h00) zeros++;
      if (exp_q.size() > 0) checkOutput("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      else extra++;
    end
    if (done) dones++;
  end

  always @(negedge CLK) begin
    if (tx_valid_g) begin
      if (strobes_g > 0) checkOutput("gap_idle_cycles", 32'(idle_run >= 5), 32'd1);
      strobes_g++;
      if (exp_g.size() > 0) checkOutput("tx_byte_g", 32'(tx_data_g), 32'(exp_g.pop_front()));
      else extra_g++;
    end
    if (done_g) dones_g++;
    if (tx_valid_g || !tx_idle_g) idle_run = 0;
    else idle_run++;
  end

  // Run one finite burst on dut; EN drops when DONE appears so no restart follows.
  task automatic applyStimulus(input logic [1:0] mode, input int len, input bit use_model);
    logic [7:0] b;
    int d0, s0, limit;
    bit seen;
    b = START;
    if (use_model) begin
      for (int i = 0; i < len; i++) begin
        exp_q.push_back(b);
        b = modelNext(mode, b);
      end
    end
    d0 = dones;
    s0 = strobes;
    seen = 1'b0;
    limit = len * 30 + 100;
    @(negedge CLK);
    MODE = mode;
    BURST_LEN = CNT_W'(len);
    EN = 1'b1;
    for (int c = 0; c < limit && !seen; c++) begin
      @(negedge CLK);
      if (c == 2) begin
        MODE = ~mode;
        BURST_LEN = CNT_W'(len + 7);
      end
      if (done) begin
        seen = 1'b1;
        EN = 1'b0;
      end
    end
    checkOutput("done_seen", 32'(seen), 32'd1);
    repeat (20) @(negedge CLK);
    checkOutput("done_pulses", 32'(dones - d0), 32'd1);
    checkOutput("strobe_count", 32'(strobes - s0), 32'(len));
    checkOutput("sent_count", 32'(sent_count), 32'(len));
    checkOutput("busy_after_done", 32'(busy), 32'd0);
    checkOutput("err_clear", 32'(err), 32'd0);
    checkOutput("queue_left", 32'(exp_q.size()), 32'd0);
    checkOutput("extra_strobes", 32'(extra), 32'd0);
  endtask

  initial begin
    int n, k, d0, s0;
    bit got;

    $display("[TB] reset values");
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("rst_tx_data", 32'(tx_data), 32'h30);
    checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_sent", 32'(sent_count), 32'd0);
    RST = 1'b0;

    $display("[TB] ramp-hold and ramp-wrap bursts");
    applyStimulus(2'd0, 12, 1'b1);
    applyStimulus(2'd1, 12, 1'b1);

    $display("[TB] LFSR bursts");
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h60);
    exp_q.push_back(8'hC1);
    exp_q.push_back(8'h82);
    applyStimulus(2'd3, 4, 1'b0);
    applyStimulus(2'd3, 255, 1'b1);
    checkOutput("lfsr_no_zero", 32'(zeros), 32'd0);

    $display("[TB] handshake timeout");
    stuck = 1'b1;
    exp_q.push_back(8'h30);
    d0 = dones;
    s0 = strobes;
    @(negedge CLK);
    MODE = 2'd0;
    BURST_LEN = 16'd5;
    EN = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge CLK);
      if (tx_valid) got = 1'b1;
    end
    checkOutput("tmo_strobe_seen", 32'(got), 32'd1);
    n = 0;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge CLK);
      n++;
      if (err) begin
        got = 1'b1;
        EN = 1'b0;
      end
    end
    EN = 1'b0;
    checkOutput("tmo_err_set", 32'(err), 32'd1);
    checkOutput("tmo_cycles", 32'(n >= 15 && n <= 16), 32'd1);
    checkOutput("tmo_busy", 32'(busy), 32'd0);
    repeat (10) @(negedge CLK);
    checkOutput("tmo_err_sticky", 32'(err), 32'd1);
    checkOutput("tmo_no_done", 32'(dones - d0), 32'd0);
    checkOutput("tmo_one_strobe", 32'(strobes - s0), 32'd1);
    stuck = 1'b0;

    $display("[TB] constant burst clears error");
    applyStimulus(2'd2, 3, 1'b1);

    $display("[TB] continuous stream with gap, abort mid-byte");
    exp_g.push_back(8'h30);
    exp_g.push_back(8'h31);
    exp_g.push_back(8'h32);
    @(negedge CLK);
    MODE = 2'd1;
    BURST_LEN = '0;
    EN_G = 1'b1;
    k = 0;
    for (int c = 0; c < 500 && k < 3; c++) begin
      @(negedge CLK);
      if (tx_valid_g) k++;
      if (k == 3) EN_G = 1'b0;
    end
    EN_G = 1'b0;
    repeat (60) @(negedge CLK);
    checkOutput("abort_strobes", 32'(strobes_g), 32'd3);
    checkOutput("abort_extra", 32'(extra_g), 32'd0);
    checkOutput("abort_no_done", 32'(dones_g), 32'd0);
    checkOutput("abort_busy", 32'(busy_g), 32'd0);
    checkOutput("abort_sent", 32'(sent_count_g), 32'd3);
    checkOutput("abort_err", 32'(err_g), 32'd0);

    $display("[TB] reset while waiting for transmitter");
    exp_q.push_back(8'h30);
    @(negedge CLK);
    MODE = 2'd1;
    BURST_LEN = '0;
    EN = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge CLK);
      if (tx_valid) got = 1'b1;
    end
    checkOutput("rst6_strobe_seen", 32'(got), 32'd1);
    repeat (3) @(negedge CLK);
    checkOutput("rst6_in_wait_hi", 32'(busy && !tx_idle), 32'd1);
    RST = 1'b1;
    EN = 1'b0;
    @(negedge CLK);
    checkOutput("rst6_tx_data", 32'(tx_data), 32'h30);
    checkOutput("rst6_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("rst6_busy", 32'(busy), 32'd0);
    checkOutput("rst6_done", 32'(done), 32'd0);
    checkOutput("rst6_err", 32'(err), 32'd0);
    checkOutput("rst6_sent", 32'(sent_count), 32'd0);
    RST = 1'b0;
    applyStimulus(2'd1, 3, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
